// File: rtl/sprite_blit_pkg.sv
// Purpose: shared blitter/display types, default geometry and the blit FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_blit_pkg;

    // Default geometry: 240x180 RGB444 framebuffer fed from a 240-pixel-stride source
    localparam int FB_W_DEF  = 240;
    localparam int FB_H_DEF  = 180;
    localparam int SRC_W_DEF = 240;
    localparam int PIX_W_DEF = 12;

    localparam int ADDR_W  = 16;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Geometry of one blit request, captured on an accepted start
    typedef struct packed {
        logic [COORD_W-1:0] src_h;
        logic [COORD_W-1:0] src_v;
        logic [COORD_W-1:0] dst_h;
        logic [COORD_W-1:0] dst_v;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } geom_t;

endpackage

// File: rtl/blit_addr_calc.sv
// Purpose: linear address of (pivot + offset) in a surface of the given row stride.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module blit_addr_calc
    import sprite_blit_pkg::*;
#(
    parameter int STRIDE = SRC_W_DEF
) (
    input  logic [COORD_W-1:0] pivot_h,
    input  logic [COORD_W-1:0] pivot_v,
    input  logic [COORD_W-1:0] off_h,
    input  logic [COORD_W-1:0] off_v,
    output logic [COORD_W:0]   pos_h,
    output logic [COORD_W:0]   pos_v,
    output logic [ADDR_W-1:0]  addr
);

    // Full-width product; the surface wraps modulo 64K, so only the low bits leave
    logic [31:0] full_addr;
    logic        unused_hi;

    // 11-bit sums keep the carry so clipping sees the true coordinate
    assign pos_h     = {1'b0, pivot_h} + {1'b0, off_h};
    assign pos_v     = {1'b0, pivot_v} + {1'b0, off_v};
    assign full_addr = 32'(pos_h) + 32'(STRIDE) * 32'(pos_v);
    assign addr      = full_addr[ADDR_W-1:0];
    assign unused_hi = ^full_addr[31:ADDR_W];

endmodule

// File: rtl/sprite_blit.sv
// Purpose: copy a width x height rectangle from source memory into the framebuffer with clip and colour key.
// Latency: first source read 1 cycle after start, each write 1 cycle after its read, done 2+W*H cycles after start.
// Backpressure: none; one pixel per cycle, start ignored unless idle.
module sprite_blit
    import sprite_blit_pkg::*;
#(
    parameter int FB_W  = FB_W_DEF,
    parameter int FB_H  = FB_H_DEF,
    parameter int SRC_W = SRC_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         src_pivot_h,
    input  logic [9:0]         src_pivot_v,
    input  logic [9:0]         dst_pivot_h,
    input  logic [9:0]         dst_pivot_v,
    input  logic [9:0]         width,
    input  logic [9:0]         height,
    input  logic               key_en,
    input  logic [PIX_W-1:0]   key_color,
    output logic [15:0]        src_addr,
    input  logic [PIX_W-1:0]   src_data,
    output logic               fb_we,
    output logic [15:0]        fb_addr,
    output logic [PIX_W-1:0]   fb_wdata,
    output logic               busy,
    output logic               done
);

    state_t              state_q, state_d;
    geom_t               geom_q;
    logic                key_en_q;
    logic [PIX_W-1:0]    key_color_q;
    logic [COORD_W-1:0]  x_q, y_q;
    logic                x_last, y_last, accept, zero_req;

    // Write stage: the pixel issued last cycle, whose data arrives this cycle
    logic                wr_pend_q, wr_inb_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                key_hit;

    logic [COORD_W:0]    dst_pos_h, dst_pos_v;
    logic [ADDR_W-1:0]   dst_addr;
    logic [COORD_W:0]    unused_src_pos_h, unused_src_pos_v;

    assign accept   = (state_q == IDLE) && start;
    assign zero_req = (width == '0) || (height == '0);
    assign x_last   = (x_q == geom_q.width  - 10'd1);
    assign y_last   = (y_q == geom_q.height - 10'd1);

    blit_addr_calc #(.STRIDE(SRC_W)) u_src_addr (
        .pivot_h (geom_q.src_h),
        .pivot_v (geom_q.src_v),
        .off_h   (x_q),
        .off_v   (y_q),
        .pos_h   (unused_src_pos_h),
        .pos_v   (unused_src_pos_v),
        .addr    (src_addr)
    );

    blit_addr_calc #(.STRIDE(FB_W)) u_dst_addr (
        .pivot_h (geom_q.dst_h),
        .pivot_v (geom_q.dst_v),
        .off_h   (x_q),
        .off_v   (y_q),
        .pos_h   (dst_pos_h),
        .pos_v   (dst_pos_v),
        .addr    (dst_addr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and status outputs; a zero-area request skips straight to DONE
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = zero_req ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (x_last && y_last) state_d = FLUSH;
            end
            FLUSH: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on accept, then walk x/y in raster order while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            geom_q      <= '0;
            key_en_q    <= 1'b0;
            key_color_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else if (accept) begin
            geom_q      <= '{src_h: src_pivot_h, src_v: src_pivot_v,
                             dst_h: dst_pivot_h, dst_v: dst_pivot_v,
                             width: width, height: height};
            key_en_q    <= key_en;
            key_color_q <= key_color;
            x_q         <= '0;
            y_q         <= '0;
        end else if (state_q == RUN) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_q + 10'd1;
            end else begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    // Delay the destination address and clip result to line up with returning source data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            wr_inb_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_pend_q <= (state_q == RUN);
            wr_inb_q  <= (dst_pos_h < 11'(FB_W)) && (dst_pos_v < 11'(FB_H));
            wr_addr_q <= dst_addr;
        end
    end

    // Colour key is judged on the data actually returned, so it lives in the write stage
    assign key_hit  = key_en_q && (src_data == key_color_q);
    assign fb_we    = wr_pend_q && wr_inb_q && !key_hit;
    assign fb_addr  = wr_addr_q;
    assign fb_wdata = wr_pend_q ? src_data : '0;

endmodule

// File: doc/sprite_blit.md
SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 SHALL have parameter FB_W, default 240: framebuffer row stride and clip width in pixels.
REQ-002 SHALL have parameter FB_H, default 180: framebuffer clip height in rows.
REQ-003 SHALL have parameter SRC_W, default 240: source memory row stride in pixels.
REQ-004 SHALL have parameter PIX_W, default 12: pixel width (RGB444).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 src_pivot_h, src_pivot_v  in  10 each  sprite origin in source memory.
REQ-009 dst_pivot_h, dst_pivot_v  in  10 each  destination origin in framebuffer.
REQ-010 width, height  in  10 each  rectangle size in pixels.
REQ-011 key_en  in  1  enables transparent colour-key skip.
REQ-012 key_color  in  PIX_W  transparent colour.
REQ-013 src_addr  out  16  source read address; memory returns data one cycle later.
REQ-014 src_data  in  PIX_W  source pixel for the address of the previous cycle.
REQ-015 fb_we, fb_addr[15:0], fb_wdata[PIX_W-1:0]  out  framebuffer write port.
REQ-016 busy, done  out  1 each  operation in progress; one-cycle completion pulse.

Function
REQ-017 SHALL latch all request inputs on an accepted start; input changes during the operation SHALL have no effect.
REQ-018 FSM states SHALL be IDLE, RUN, FLUSH, DONE: IDLE->RUN on start with width,height nonzero; IDLE->DONE on start with width or height zero; RUN->FLUSH after issuing the last pixel; FLUSH->DONE; DONE->IDLE unconditionally.
REQ-019 In RUN, x SHALL step 0..width-1 per cycle; y SHALL increment on x wrap; raster order, one pixel per cycle, no stalls.
REQ-020 src_addr SHALL equal (src_pivot_h+x) + SRC_W*(src_pivot_v+y), computed at 17 bits or wider and truncated to 16 bits.
REQ-021 A pixel issued in cycle C SHALL be written in cycle C+1, with fb_addr = (dst_pivot_h+x) + FB_W*(dst_pivot_v+y) (truncated to 16 bits) and fb_wdata = src_data.
REQ-022 fb_we SHALL be suppressed when dst_pivot_h+x >= FB_W or dst_pivot_v+y >= FB_H, compared at 11 bits without wrap.
REQ-023 fb_we SHALL be suppressed when key_en=1 and src_data == key_color.
REQ-024 With start in cycle N, the first src_addr SHALL appear in N+1, the first write slot in N+2, the last write slot in N+1+W*H, and done in N+2+W*H.
REQ-025 busy SHALL be high in RUN and FLUSH and low in IDLE and DONE; done SHALL be high only in DONE.
REQ-026 start during busy or DONE SHALL be ignored, not queued.
REQ-027 fb_we SHALL be 0 in IDLE, DONE and the first RUN cycle.
REQ-028 A zero-size request SHALL produce no writes and done in N+1.

Reset
REQ-029 rst SHALL force IDLE asynchronously with x=y=0, busy=0, done=0, fb_we=0, src_addr=0, fb_addr=0, fb_wdata=0.
REQ-030 rst mid-operation SHALL abort with no further writes and no done pulse; the next start after rst deasserts SHALL be accepted.

Structure
REQ-031 FSM state encoding and default FB_W/FB_H/SRC_W/PIX_W values SHALL reside in a shared package used by the display-side address generator.
REQ-032 The pivot-plus-offset times stride address computation SHALL be one sub-module, blit_addr_calc, instantiated twice (source and destination).

Verification
REQ-033 src 0,0; dst 10,20; 3x2; key off; src_data = low 12 bits of the previous src_addr -> 6 writes at fb_addr 4810,4811,4812,5050,5051,5052 in consecutive cycles N+2..N+7; done at N+8.
REQ-034 dst 238,179; 4x2 -> 8 RUN cycles, only writes to 43198,43199 (x=0,1,y=0); done at N+10.
REQ-035 key_en=1, key_color=12'h0F0, 2x1, src_data 12'h0F0 then 12'hABC -> single write, fb_wdata=12'hABC at dst_pivot_h+1.
REQ-036 width=0, height=5 -> no fb_we, busy never high, done at N+1; start repeated while busy -> ignored, exactly one done.
REQ-037 rst asserted at N+4 of a 4x4 blit -> fb_we low immediately, no done; new 1x1 start after release -> one write, done at start+3.
